// File: rtl/mem_arbiter_if.sv
// Requester-side port of the memory arbiter: one request/grant channel plus its
// registered read response.
interface mem_arbiter_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        lock;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, addr, wdata, wmask, lock,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, wdata, wmask, lock,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported unified memory.
// Supports a bounded burst lock, flags out-of-range word addresses and returns
// a per-port response one cycle behind the grant.
module mem_arbiter #(
    parameter int unsigned MEM_WORDS = 1536,
    parameter int unsigned MAX_HOLD  = 16
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  m0,
    mem_arbiter_if.slave  m1,
    output logic          mem_rstrb,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wmask,
    input  logic [31:0]   mem_rdata
);
    localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

    logic             last_gnt_q;
    logic             lock_valid_q, lock_valid_d;
    logic             lock_owner_q, lock_owner_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic             resp_valid_q, resp_owner_q, resp_err_q, err_pend_q;
    logic [31:0]      addr_q, wdata_q;

    logic [1:0]  req;
    logic        gnt_any, sel;
    logic [31:0] sel_addr, sel_wdata;
    logic [3:0]  sel_wmask;
    logic        sel_lock, sel_read, in_range, other_req;

    assign req = {m1.req, m0.req};

    // Pick the winner from registered state; nothing is granted while in reset.
    always_comb begin
        gnt_any = 1'b0;
        sel     = 1'b0;
        if (!reset) begin
            if (req == 2'b01) begin
                gnt_any = 1'b1;
                sel     = 1'b0;
            end else if (req == 2'b10) begin
                gnt_any = 1'b1;
                sel     = 1'b1;
            end else if (req == 2'b11) begin
                gnt_any = 1'b1;
                if (lock_valid_q && (hold_cnt_q < HoldW'(MAX_HOLD))) begin
                    sel = lock_owner_q;
                end else begin
                    sel = ~last_gnt_q;
                end
            end
        end
    end

    assign sel_addr  = sel ? m1.addr  : m0.addr;
    assign sel_wdata = sel ? m1.wdata : m0.wdata;
    assign sel_wmask = sel ? m1.wmask : m0.wmask;
    assign sel_lock  = sel ? m1.lock  : m0.lock;
    assign other_req = sel ? req[0]   : req[1];
    assign sel_read  = (sel_wmask == 4'b0000);
    assign in_range  = (sel_addr[31:2] < 30'(MEM_WORDS));

    assign m0.gnt = gnt_any & ~sel;
    assign m1.gnt = gnt_any & sel;

    // Out-of-range accesses are still granted but never touch the memory.
    assign mem_rstrb = gnt_any & in_range & sel_read;
    assign mem_wmask = (gnt_any && in_range) ? sel_wmask : 4'b0000;
    assign mem_addr  = reset ? 32'h0 : (gnt_any ? sel_addr : addr_q);
    assign mem_wdata = reset ? 32'h0 : (gnt_any ? sel_wdata : wdata_q);

    // Responses are masked during reset so an in-flight access is dropped.
    assign m0.rvalid = ~reset & resp_valid_q & ~resp_owner_q;
    assign m1.rvalid = ~reset & resp_valid_q & resp_owner_q;
    assign m0.err    = ~reset & err_pend_q & resp_err_q & ~resp_owner_q;
    assign m1.err    = ~reset & err_pend_q & resp_err_q & resp_owner_q;
    assign m0.rdata  = (m0.rvalid && !resp_err_q) ? mem_rdata : 32'h0;
    assign m1.rdata  = (m1.rvalid && !resp_err_q) ? mem_rdata : 32'h0;

    // Lock ownership and hold counter: the lock survives only while its owner
    // keeps winning with lock asserted; hold_cnt counts wins under contention.
    always_comb begin
        lock_valid_d = 1'b0;
        lock_owner_d = lock_owner_q;
        hold_cnt_d   = '0;
        if (gnt_any && sel_lock) begin
            lock_valid_d = 1'b1;
            lock_owner_d = sel;
            if (!other_req) begin
                hold_cnt_d = '0;
            end else if (lock_valid_q && (lock_owner_q == sel)) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end else begin
                hold_cnt_d = HoldW'(1);
            end
        end
    end

    // Arbitration history, hold address/data and the one-deep response stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_q   <= 1'b1;
            lock_valid_q <= 1'b0;
            lock_owner_q <= 1'b0;
            hold_cnt_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_owner_q <= 1'b0;
            resp_err_q   <= 1'b0;
            err_pend_q   <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            if (gnt_any) begin
                last_gnt_q   <= sel;
                addr_q       <= sel_addr;
                wdata_q      <= sel_wdata;
                resp_valid_q <= sel_read;
                resp_owner_q <= sel;
                resp_err_q   <= ~in_range;
                err_pend_q   <= 1'b1;
            end else begin
                resp_valid_q <= 1'b0;
                resp_owner_q <= 1'b0;
                resp_err_q   <= 1'b0;
                err_pend_q   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter against a transaction-level reference model,
// preceded by directed scenarios with hand-computed expectations.
module tb_mem_arbiter;
    localparam int unsigned MemWords = 1536;
    localparam int unsigned MaxHold  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if m0 ();
    mem_arbiter_if m1 ();

    logic        mem_rstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [3:0]  mem_wmask;

    logic [1:0]  r_req, r_lock;
    logic [31:0] r_addr  [2];
    logic [31:0] r_wdata [2];
    logic [3:0]  r_wmask [2];

    assign m0.req = r_req[0];   assign m1.req = r_req[1];
    assign m0.addr = r_addr[0]; assign m1.addr = r_addr[1];
    assign m0.wdata = r_wdata[0]; assign m1.wdata = r_wdata[1];
    assign m0.wmask = r_wmask[0]; assign m1.wmask = r_wmask[1];
    assign m0.lock = r_lock[0]; assign m1.lock = r_lock[1];

    mem_arbiter #(.MEM_WORDS(MemWords), .MAX_HOLD(MaxHold)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0        (m0),
        .m1        (m1),
        .mem_rstrb (mem_rstrb),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata)
    );

    // Environment memory driven by the DUT's pins.
    logic [31:0] mem [MemWords];
    int unsigned env_idx;
    always @(posedge clk) begin
        env_idx = int'(mem_addr[31:2]);
        if (env_idx < MemWords) begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) mem[env_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            if (mem_rstrb) mem_rdata <= mem[env_idx];
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [MemWords];
    int          m_last, m_lock_own, m_hold, m_g, m_rport;
    bit          m_lock_v, m_have, m_rread, m_rerr;
    logic [31:0] m_rdata, m_haddr, m_hwdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic        s_gnt [2], s_rvalid [2], s_err [2];
    logic [31:0] s_rdata [2];
    logic        s_rstrb;
    logic [31:0] s_addr;
    logic [3:0]  s_wmask;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Compare every DUT output with what the model says this cycle must show.
    task automatic check_cycle();
        int          g;
        bit          inr;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wmask;
        logic        e_rstrb;
        g = -1;
        if (!reset) begin
            if (r_req == 2'b01) g = 0;
            else if (r_req == 2'b10) g = 1;
            else if (r_req == 2'b11)
                g = (m_lock_v && m_hold < MaxHold) ? m_lock_own : 1 - m_last;
        end
        m_g = g;
        e_rstrb = 1'b0; e_wmask = 4'h0; e_addr = m_haddr; e_wdata = m_hwdata;
        if (reset) begin
            e_addr = 32'h0; e_wdata = 32'h0;
        end else if (g >= 0) begin
            inr     = (r_addr[g] >> 2) < MemWords;
            e_addr  = r_addr[g];
            e_wdata = r_wdata[g];
            e_wmask = inr ? r_wmask[g] : 4'h0;
            e_rstrb = inr && (r_wmask[g] == 4'h0);
        end
        s_gnt[0] = m0.gnt; s_gnt[1] = m1.gnt;
        s_rvalid[0] = m0.rvalid; s_rvalid[1] = m1.rvalid;
        s_err[0] = m0.err; s_err[1] = m1.err;
        s_rdata[0] = m0.rdata; s_rdata[1] = m1.rdata;
        s_rstrb = mem_rstrb; s_addr = mem_addr; s_wmask = mem_wmask;

        chk("m0_gnt", s_gnt[0], (g == 0));
        chk("m1_gnt", s_gnt[1], (g == 1));
        chk("mem_rstrb", s_rstrb, e_rstrb);
        chk("mem_wmask", s_wmask, e_wmask);
        chk("mem_addr", s_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        for (int p = 0; p < 2; p++) begin
            if (!reset && m_have && p == m_rport) begin
                chk("rvalid_owner", s_rvalid[p], m_rread);
                chk("err_owner", s_err[p], m_rerr);
                if (m_rread) chk("rdata_owner", s_rdata[p], m_rerr ? 32'h0 : m_rdata);
            end else begin
                chk("rvalid_idle", s_rvalid[p], 1'b0);
                chk("err_idle", s_err[p], 1'b0);
                if (m_have && !reset) chk("rdata_nonowner", s_rdata[p], 32'h0);
            end
        end
    endtask

    // Advance the model across the clock edge.
    task automatic update_model();
        int unsigned w;
        int          g;
        g = m_g;
        if (reset) begin
            m_last = 1; m_lock_v = 0; m_lock_own = 0; m_hold = 0;
            m_have = 0; m_haddr = 32'h0; m_hwdata = 32'h0;
            return;
        end
        if (g < 0) begin
            m_have = 0; m_lock_v = 0; m_hold = 0;
            return;
        end
        w = r_addr[g] >> 2;
        m_have = 1; m_rport = g;
        m_rread = (r_wmask[g] == 4'h0);
        m_rerr  = !(w < MemWords);
        m_rdata = m_rerr ? 32'h0 : ref_mem[w];
        if (!m_rerr)
            for (int b = 0; b < 4; b++)
                if (r_wmask[g][b]) ref_mem[w][8*b +: 8] = r_wdata[g][8*b +: 8];
        m_haddr = r_addr[g]; m_hwdata = r_wdata[g];
        // Lock belongs to whoever was just granted with lock asserted.
        if (r_lock[g]) begin
            if (!r_req[1-g]) m_hold = 0;
            else if (m_lock_v && m_lock_own == g) m_hold = m_hold + 1;
            else m_hold = 1;
            m_lock_v = 1; m_lock_own = g;
        end else begin
            m_lock_v = 0; m_hold = 0;
        end
        m_last = g;
    endtask

    task automatic step();
        #4;
        check_cycle();
        update_model();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] wm, input logic lk);
        r_req[p] = 1'b1; r_addr[p] = a; r_wdata[p] = d; r_wmask[p] = wm; r_lock[p] = lk;
    endtask

    task automatic clr_req(input int p);
        r_req[p] = 1'b0; r_lock[p] = 1'b0;
    endtask

    function automatic logic [31:0] rnd_addr();
        int unsigned k;
        int unsigned w;
        logic [31:0] a;
        k = $urandom % 100;
        if (k < 8) w = 1530 + ($urandom % 12);
        else if (k < 40) w = $urandom % 16;
        else w = $urandom % MemWords;
        a = (w << 2) | ($urandom % 4);
        if (k >= 98) a = $urandom | 32'h8000_0000;
        return a;
    endfunction

    bit   pend [2];
    bit   lmode [2];
    logic seq [7];

    initial begin
        for (int i = 0; i < int'(MemWords); i++) begin
            mem[i] = $urandom; ref_mem[i] = mem[i];
        end
        mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
        mem[8] = 32'h11223344; ref_mem[8] = 32'h11223344;
        m_last = 1; m_lock_v = 0; m_lock_own = 0; m_hold = 0; m_have = 0;
        m_haddr = 0; m_hwdata = 0; m_g = -1; m_rport = 0;
        reset = 1'b1;
        for (int p = 0; p < 2; p++) begin
            r_req[p] = 0; r_lock[p] = 0; r_addr[p] = 0; r_wdata[p] = 0; r_wmask[p] = 0;
        end
        step(); step();
        chk("reset_m0_gnt", s_gnt[0], 1'b0);
        chk("reset_mem_addr", s_addr, 32'h0);
        reset = 1'b0;

        // 1: single read of 0x10.
        set_req(0, 32'h10, 32'h0, 4'h0, 1'b0);
        step();
        chk("t1_gnt", s_gnt[0], 1'b1);
        chk("t1_rstrb", s_rstrb, 1'b1);
        chk("t1_addr", s_addr, 32'h10);
        clr_req(0);
        step();
        chk("t1_rvalid", s_rvalid[0], 1'b1);
        chk("t1_rdata", s_rdata[0], 32'hDEADBEEF);
        chk("t1_m1_rvalid", s_rvalid[1], 1'b0);

        // 2: both request without lock -> alternation (m0 won last).
        set_req(0, 32'h10, 32'h0, 4'h0, 1'b0);
        set_req(1, 32'h20, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_alt_m1", s_gnt[1], (i % 2 == 0));
        end

        // 3: m1 locks -> four m1 grants, then m0, then alternation.
        set_req(1, 32'h24, 32'h0, 4'h0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            if (i == 5) r_lock[1] = 1'b0;
            step();
            seq[i] = s_gnt[1];
        end
        chk("t3_seq", {seq[0], seq[1], seq[2], seq[3], seq[4], seq[5], seq[6]}, 7'b1111010);
        clr_req(0); clr_req(1);
        step();

        // 4: partial write then read of the same word.
        set_req(0, 32'h20, 32'h0000AB00, 4'b0010, 1'b0);
        step();
        set_req(0, 32'h20, 32'h0, 4'h0, 1'b0);
        step();
        clr_req(0);
        step();
        chk("t4_rdata", s_rdata[0], 32'h1122AB44);

        // 5: out-of-range read, then write.
        set_req(1, 32'h1800, 32'h0, 4'h0, 1'b0);
        step();
        chk("t5_gnt", s_gnt[1], 1'b1);
        chk("t5_rstrb", s_rstrb, 1'b0);
        set_req(1, 32'h1800, 32'hFFFFFFFF, 4'hF, 1'b0);
        step();
        chk("t5_rvalid", s_rvalid[1], 1'b1);
        chk("t5_rdata", s_rdata[1], 32'h0);
        chk("t5_err", s_err[1], 1'b1);
        chk("t5_wmask", s_wmask, 4'h0);
        clr_req(1);
        step();
        chk("t5_werr", s_err[1], 1'b1);
        chk("t5_wrvalid", s_rvalid[1], 1'b0);

        // 6: reset right after a read grant drops the response.
        set_req(0, 32'h10, 32'h0, 4'h0, 1'b0);
        step();
        clr_req(0);
        reset = 1'b1;
        step();
        chk("t6_rvalid", s_rvalid[0], 1'b0);
        step();
        reset = 1'b0;
        set_req(0, 32'h30, 32'h0, 4'h0, 1'b0);
        set_req(1, 32'h34, 32'h0, 4'h0, 1'b0);
        step();
        chk("t6_first_m0", s_gnt[0], 1'b1);
        clr_req(0); clr_req(1);
        step();

        // Random traffic.
        pend[0] = 0; pend[1] = 0; lmode[0] = 0; lmode[1] = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom % 500 == 0) begin
                reset = 1'b1; pend[0] = 0; pend[1] = 0;
            end else begin
                reset = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                if (!reset && !pend[p] && ($urandom % 4 != 0)) begin
                    if ($urandom % 16 == 0) lmode[p] = ~lmode[p];
                    set_req(p, rnd_addr(), $urandom,
                            ($urandom % 2 == 0) ? 4'h0 : 4'($urandom), lmode[p]);
                    pend[p] = 1;
                end
                r_req[p] = pend[p];
            end
            step();
            if (m_g >= 0) pend[m_g] = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
